// File: rtl/err_inject_channel.sv
// err_inject_channel
//   Sits between an ECC encoder and decoder and flips chosen bits of
//   selected codewords. It is a one-stage registered pipeline with a
//   valid/ready handshake on both sides.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      din is valid
//   in_ready      block accepts din this cycle
//   din           codeword from the encoder
//   cfg_mode      0 none, 1 single, 2 double, 3 burst
//   cfg_period    inject every cfg_period-th accepted word (0 = off)
//   force_inject  inject on the word accepted this cycle
//   error_pos1/2  bit positions used by the error modes
//   out_valid     dout is valid
//   out_ready     decoder accepts dout
//   dout          possibly corrupted codeword
//   err_mask      bits flipped in dout (dout = din ^ err_mask)
//   injected      err_mask is nonzero for this word
//   err_count     injected words since reset, saturating
module err_inject_channel #(
  parameter int DATA_WIDTH = 39,
  parameter int POS_WIDTH  = $clog2(DATA_WIDTH),
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_period,
  input  logic                  force_inject,
  input  logic [POS_WIDTH-1:0]  error_pos1,
  input  logic [POS_WIDTH-1:0]  error_pos2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] err_mask,
  output logic                  injected,
  output logic [15:0]           err_count
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Positions can exceed DATA_WIDTH-1 because POS_WIDTH rounds up to a
  // power of two; one subtraction always brings them into range.
  function automatic int reduce_pos(input logic [POS_WIDTH-1:0] p);
    int v;
    v = int'(p);
    if (v >= DATA_WIDTH) v = v - DATA_WIDTH;
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] build_mask(input logic [1:0] mode,
                                                       input int p1, input int p2);
    logic [DATA_WIDTH-1:0] m;
    int q;
    m = '0;
    q = 0;
    case (mode)
      2'd1: m = ONE << p1;
      2'd2: begin
        // Coincident positions still give two flips: use the next bit up.
        if (p2 == p1) q = (p1 + 1 == DATA_WIDTH) ? 0 : p1 + 1;
        else          q = p2;
        m = (ONE << p1) | (ONE << q);
      end
      2'd3: begin
        for (int k = 0; k < BURST_LEN; k++) begin
          q = p1 + k;
          if (q >= DATA_WIDTH) q = q - DATA_WIDTH;
          m = m | (ONE << q);
        end
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [DATA_WIDTH-1:0] mask_p1;
  logic                  inj_p1;
  logic [7:0]            word_cnt;

  logic                  accept_p0;
  logic                  hit_p0;
  logic                  inject_p0;
  int                    p1_p0;
  int                    p2_p0;
  logic [DATA_WIDTH-1:0] mask_p0;

  // Stage p0: acceptance, injection decision and mask generation
  assign in_ready  = rst | ~vld_p1 | out_ready;
  assign accept_p0 = in_valid & in_ready;
  assign hit_p0    = (cfg_period != 8'd0) && (word_cnt == cfg_period - 8'd1);
  assign inject_p0 = (cfg_mode != 2'd0) && (hit_p0 || force_inject);
  assign p1_p0     = reduce_pos(error_pos1);
  assign p2_p0     = reduce_pos(error_pos2);
  assign mask_p0   = inject_p0 ? build_mask(cfg_mode, p1_p0, p2_p0) : '0;

  // Stage p1: output register, held while the decoder stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      mask_p1   <= '0;
      inj_p1    <= 1'b0;
      word_cnt  <= 8'd0;
      err_count <= 16'd0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      data_p1  <= din ^ mask_p0;
      mask_p1  <= mask_p0;
      inj_p1   <= inject_p0;
      word_cnt <= hit_p0 ? 8'd0 : word_cnt + 8'd1;
      if (inject_p0 && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign dout      = data_p1;
  assign err_mask  = mask_p1;
  assign injected  = inj_p1;

endmodule

// File: tb/tb_err_inject_channel.sv
module tb_err_inject_channel;

  localparam int W  = 39;
  localparam int PW = 6;
  localparam int BL = 4;
  localparam logic [W-1:0] ONE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  din = '0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [7:0]    cfg_period = 8'd0;
  logic          force_inject = 1'b0;
  logic [PW-1:0] error_pos1 = '0;
  logic [PW-1:0] error_pos2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  dout;
  logic [W-1:0]  err_mask;
  logic          injected;
  logic [15:0]   err_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  err_inject_channel #(.DATA_WIDTH(W), .POS_WIDTH(PW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .force_inject(force_inject),
    .error_pos1(error_pos1), .error_pos2(error_pos2), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .err_mask(err_mask), .injected(injected),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: set of flipped positions derived directly from the mode rules.
  function automatic logic [W-1:0] ref_mask(input int mode, input int p1, input int p2);
    logic [W-1:0] m;
    int a, b;
    m = '0;
    a = p1 % W;
    b = p2 % W;
    if (mode == 1) m = ONE << a;
    if (mode == 2) m = (ONE << a) | (ONE << ((b == a) ? (a + 1) % W : b));
    if (mode == 3) for (int k = 0; k < BL; k++) m = m | (ONE << ((a + k) % W));
    return m;
  endfunction

  // Behavioural model: what the output slot holds after each edge.
  bit         m_vld = 0;
  logic [W-1:0] m_dout = '0, m_mask = '0;
  bit         m_inj = 0;
  int         m_cnt = 0;
  int         m_errc = 0;

  always @(posedge clk) begin
    bit acc, hit, inj;
    logic [W-1:0] mk;
    if (rst) begin
      m_vld = 0; m_dout = '0; m_mask = '0; m_inj = 0; m_cnt = 0; m_errc = 0;
    end else begin
      acc = in_valid && (!m_vld || out_ready);
      if (acc) begin
        hit = (cfg_period != 0) && (m_cnt == int'(cfg_period) - 1);
        m_cnt = hit ? 0 : (m_cnt + 1) % 256;
        inj = (cfg_mode != 0) && (hit || force_inject);
        mk = inj ? ref_mask(int'(cfg_mode), int'(error_pos1), int'(error_pos2)) : '0;
        m_dout = din ^ mk;
        m_mask = mk;
        m_inj = inj;
        m_vld = 1;
        if (inj && m_errc < 65535) m_errc++;
      end else if (out_ready) begin
        m_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, rst || !m_vld || out_ready);
      chk("out_valid", out_valid, m_vld);
      chk("dout", dout, m_dout);
      chk("err_mask", err_mask, m_mask);
      chk("injected", injected, m_inj);
      chk("err_count", err_count, m_errc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit v, input logic [W-1:0] d, input logic [1:0] mode,
                        input logic [7:0] per, input bit f, input int p1, input int p2,
                        input bit ordy);
    in_valid = v; din = d; cfg_mode = mode; cfg_period = per; force_inject = f;
    error_pos1 = PW'(p1); error_pos2 = PW'(p2); out_ready = ordy;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] d, held;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset err_count", err_count, 0);
    chk("reset in_ready", in_ready, 1);
    rst = 1'b0;

    // Single flip, period 1
    set_in(1, '0, 2'd1, 8'd1, 0, 5, 0, 1);
    tick();
    chk("single out_valid", out_valid, 1);
    chk("single dout", dout, 39'h20);
    chk("single mask", err_mask, 39'h20);
    chk("single injected", injected, 1);
    chk("single err_count", err_count, 1);

    // Double flip with equal positions at the MSB
    d = rnd_word();
    set_in(1, d, 2'd2, 8'd0, 1, 38, 38, 1);
    tick();
    chk("double mask", err_mask, 39'h40_0000_0001);
    chk("double dout", dout, d ^ 39'h40_0000_0001);

    // Burst wrapping past the MSB
    set_in(1, '0, 2'd3, 8'd0, 1, 37, 0, 1);
    tick();
    chk("burst mask", err_mask, 39'h60_0000_0003);

    // Out-of-range position folds back (63 -> 24)
    set_in(1, '0, 2'd1, 8'd0, 1, 63, 0, 1);
    tick();
    chk("fold mask", err_mask, 39'h00_0100_0000);

    // Period 3 over 9 back-to-back words
    set_in(0, '0, 2'd0, 8'd0, 0, 0, 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      set_in(1, W'(i), 2'd1, 8'd3, 0, 2, 0, 1);
      tick();
      chk($sformatf("period3 word%0d", i), injected, (i % 3) == 0);
    end
    chk("period3 err_count", err_count, 3);

    // Stall for 5 cycles with a word held
    set_in(0, '0, 2'd0, 8'd0, 0, 0, 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    held = rnd_word();
    set_in(1, held, 2'd0, 8'd0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      din = rnd_word();
      tick();
      chk("stall dout", dout, held);
      chk("stall in_ready", in_ready, 0);
    end
    // Counter must still be 1 here, so period 2 hits on this word.
    set_in(1, '0, 2'd1, 8'd2, 0, 0, 0, 1);
    tick();
    chk("post-stall injected", injected, 1);
    chk("post-stall mask", err_mask, 39'h1);

    // Reset while a word is held
    set_in(0, '0, 2'd0, 8'd0, 0, 0, 0, 0);
    tick();
    chk("held before reset", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("in_ready during reset", in_ready, 1);
    tick();
    chk("reset drops out_valid", out_valid, 0);
    chk("reset clears err_count", err_count, 0);
    chk("reset clears dout", dout, 0);
    rst = 1'b0;

    // Saturation of err_count
    for (int i = 0; i < 65540; i++) begin
      set_in(1, rnd_word(), 2'd1, 8'd0, 1, int'($urandom_range(0, 63)), 0, 1);
      tick();
    end
    chk("err_count saturated", err_count, 16'hFFFF);
    chk("saturated still injects", injected, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 3) != 0, rnd_word(), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)),
             $urandom_range(0, 7) == 0, int'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
